// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types and encodings for the sequential 4x4 multiply/divide controller
// and its combinational iteration step.
package alu_muldiv_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_INC = 2'b10;
    localparam logic [1:0] ALU_NEG = 2'b11;

    localparam int unsigned ITERATIONS = 4;

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One shift-and-add multiply or restoring-divide iteration: chooses the ALU
// operands for the current {hi, lo} and folds the ALU answer into the next value.
module muldiv_step
    import alu_muldiv_seq_pkg::*;
(
    input  logic       op,
    input  logic [3:0] hi,
    input  logic [3:0] lo,
    input  logic [3:0] y,
    input  logic [3:0] alu_r,
    input  logic       alu_carry,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_aluop,
    output logic [3:0] hi_next,
    output logic [3:0] lo_next
);

    logic [4:0] t;
    logic       q;
    logic       c;
    logic [3:0] s;

    always_comb begin
        t         = {hi, lo[3]};
        q         = 1'b0;
        c         = 1'b0;
        s         = hi;
        alu_b     = y;
        alu_a     = hi;
        alu_aluop = ALU_ADD;
        hi_next   = hi;
        lo_next   = lo;
        if (op == OP_DIV) begin
            // Subtract succeeds when the shifted-out bit was set or there was no borrow.
            alu_a     = t[3:0];
            alu_aluop = ALU_SUB;
            q         = t[4] | alu_carry;
            hi_next   = q ? alu_r : t[3:0];
            lo_next   = {lo[2:0], q};
        end else begin
            if (lo[0]) begin
                c = alu_carry;
                s = alu_r;
            end
            hi_next = {c, s[3:1]};
            lo_next = {s[0], lo[3:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential 4x4 unsigned multiplier/divider that drives an external nibble ALU
// for four passes per command and holds the result until the consumer takes it.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       op,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       done_valid,
    input  logic       done_ready,
    output logic [3:0] hi,
    output logic [3:0] lo,
    output logic       res_zero,
    output logic       div_by_zero,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_aluop,
    output logic       alu_l,
    input  logic [3:0] alu_r,
    input  logic       alu_carry,
    input  logic       alu_zero,
    input  logic       alu_sign
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and commands offered while busy are dropped.
    state_t     state;
    state_t     state_next;
    logic [1:0] cnt;
    logic       op_q;
    logic [3:0] y_q;
    logic [3:0] step_a;
    logic [3:0] step_b;
    logic [1:0] step_aluop;
    logic [3:0] hi_next;
    logic [3:0] lo_next;
    logic       unused_flags;

    assign unused_flags = alu_zero ^ alu_sign;

    muldiv_step u_step (
        .op        (op_q),
        .hi        (hi),
        .lo        (lo),
        .y         (y_q),
        .alu_r     (alu_r),
        .alu_carry (alu_carry),
        .alu_a     (step_a),
        .alu_b     (step_b),
        .alu_aluop (step_aluop),
        .hi_next   (hi_next),
        .lo_next   (lo_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        alu_a       = 4'd0;
        alu_b       = 4'd0;
        alu_aluop   = ALU_ADD;
        alu_l       = 1'b0;
        case (state)
            IDLE: begin
                start_ready = rst_n;
                if (start_valid) state_next = RUN;
            end
            RUN: begin
                alu_a     = step_a;
                alu_b     = step_b;
                alu_aluop = step_aluop;
                if (cnt == 2'(ITERATIONS - 1)) state_next = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 2'd0;
            op_q        <= OP_MUL;
            y_q         <= 4'd0;
            hi          <= 4'd0;
            lo          <= 4'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    cnt         <= 2'd0;
                    op_q        <= op;
                    y_q         <= y;
                    hi          <= 4'd0;
                    lo          <= x;
                    div_by_zero <= (op == OP_DIV) && (y == 4'd0);
                end
                RUN: begin
                    cnt <= cnt + 2'd1;
                    hi  <= hi_next;
                    lo  <= lo_next;
                end
                default: ;
            endcase
        end
    end

    assign res_zero = ({hi, lo} == 8'd0);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural nibble ALU on the alu_* port.
module tb_alu_muldiv_seq;

    logic       clk;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic       op;
    logic [3:0] x;
    logic [3:0] y;
    logic       done_valid;
    logic       done_ready;
    logic [3:0] hi;
    logic [3:0] lo;
    logic       res_zero;
    logic       div_by_zero;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_aluop;
    logic       alu_l;
    logic [3:0] alu_r;
    logic       alu_carry;
    logic       alu_zero;
    logic       alu_sign;

    int errors = 0;
    int checks = 0;

    alu_muldiv_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .x           (x),
        .y           (y),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .hi          (hi),
        .lo          (lo),
        .res_zero    (res_zero),
        .div_by_zero (div_by_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_aluop   (alu_aluop),
        .alu_l       (alu_l),
        .alu_r       (alu_r),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .alu_sign    (alu_sign)
    );

    // Behavioural ALU: 00 a+b, 01 a+~b+1, 10 b+1, 11 -b; carry is the 5th sum bit.
    logic [4:0] alu_sum;
    always_comb begin
        case (alu_aluop)
            2'b00:   alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
            2'b10:   alu_sum = {1'b0, alu_b} + 5'd1;
            default: alu_sum = {1'b0, ~alu_b} + 5'd1;
        endcase
    end
    assign alu_r     = alu_sum[3:0];
    assign alu_carry = alu_sum[4];
    assign alu_zero  = (alu_sum[3:0] == 4'd0);
    assign alu_sign  = alu_sum[3];

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a command at a negedge, let it be accepted, then wait (bounded) for done.
    task automatic issue_cmd(input logic o, input logic [3:0] xv, input logic [3:0] yv,
                             output int lat);
        start_valid = 1'b1;
        op = o;
        x = xv;
        y = yv;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        lat = 0;
        while (!done_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume_done();
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_valid = 1'b0;
        done_ready = 1'b0;
        op = 1'b0;
        x = 4'd0;
        y = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({start_ready, done_valid, hi, lo, div_by_zero} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b dv=%b hi=%h lo=%h dbz=%b, need 1 0 0 0 0",
                     start_ready, done_valid, hi, lo, div_by_zero);
        end
        checks++;
        if ({alu_a, alu_b, alu_aluop, alu_l} !== 11'd0) begin
            errors++;
            $display("FAIL reset_alu_idle: got a=%h b=%h op=%b l=%b, need zeros",
                     alu_a, alu_b, alu_aluop, alu_l);
        end
    endtask

    task automatic test_mul();
        int lat;
        issue_cmd(1'b0, 4'd7, 4'd6, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL mul_7x6_latency: got %0d cycles, need 4", lat);
        end
        checks++;
        if ({hi, lo, res_zero, start_ready} !== {8'h2A, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mul_7x6: got hi=%h lo=%h rz=%b rdy=%b, need 2 a 0 0", hi, lo, res_zero, start_ready);
        end
        consume_done();
        checks++;
        if ({done_valid, start_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mul_consume: got dv=%b rdy=%b, need 0 1", done_valid, start_ready);
        end

        issue_cmd(1'b0, 4'hF, 4'hF, lat);
        checks++;
        if ({lat == 4, hi, lo} !== {1'b1, 8'hE1}) begin
            errors++;
            $display("FAIL mul_FxF: got lat=%0d hi=%h lo=%h, need 4 e 1", lat, hi, lo);
        end
        consume_done();

        issue_cmd(1'b0, 4'd0, 4'd9, lat);
        checks++;
        if ({lat == 4, hi, lo, res_zero} !== {1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL mul_0x9: got lat=%0d hi=%h lo=%h rz=%b, need 4 0 0 1", lat, hi, lo, res_zero);
        end
        consume_done();
    endtask

    task automatic test_div();
        int lat;
        issue_cmd(1'b1, 4'd13, 4'd4, lat);
        checks++;
        if ({lat == 4, hi, lo, div_by_zero} !== {1'b1, 4'h1, 4'h3, 1'b0}) begin
            errors++;
            $display("FAIL div_13_4: got lat=%0d rem=%h quo=%h dbz=%b, need 4 1 3 0", lat, hi, lo, div_by_zero);
        end
        consume_done();

        issue_cmd(1'b1, 4'd15, 4'd1, lat);
        checks++;
        if ({hi, lo} !== 8'h0F) begin
            errors++;
            $display("FAIL div_15_1: got rem=%h quo=%h, need 0 f", hi, lo);
        end
        consume_done();

        issue_cmd(1'b1, 4'd14, 4'd15, lat);
        checks++;
        if ({hi, lo, res_zero} !== {8'hE0, 1'b0}) begin
            errors++;
            $display("FAIL div_14_15: got rem=%h quo=%h rz=%b, need e 0 0", hi, lo, res_zero);
        end
        consume_done();
    endtask

    task automatic test_div_by_zero();
        int lat;
        issue_cmd(1'b1, 4'd9, 4'd0, lat);
        checks++;
        if ({lat == 4, hi, lo, div_by_zero} !== {1'b1, 4'h9, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL div_9_0: got lat=%0d rem=%h quo=%h dbz=%b, need 4 9 f 1", lat, hi, lo, div_by_zero);
        end
        consume_done();

        issue_cmd(1'b0, 4'd2, 4'd3, lat);
        checks++;
        if ({hi, lo, div_by_zero} !== {8'h06, 1'b0}) begin
            errors++;
            $display("FAIL mul_after_dbz: got hi=%h lo=%h dbz=%b, need 0 6 0", hi, lo, div_by_zero);
        end
        consume_done();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue_cmd(1'b0, 4'd7, 4'd6, lat);
        for (int i = 0; i < 3; i++) begin
            start_valid = 1'b1;
            op = 1'(i);
            x = 4'(i + 1);
            y = 4'd2;
            @(negedge clk);
            checks++;
            if ({done_valid, start_ready, hi, lo, res_zero, div_by_zero} !== {1'b1, 1'b0, 8'h2A, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got dv=%b rdy=%b hi=%h lo=%h rz=%b dbz=%b, need 1 0 2 a 0 0",
                         i, done_valid, start_ready, hi, lo, res_zero, div_by_zero);
            end
        end
        // Consume and offer a new start in the same cycle: only the done transfers.
        op = 1'b0;
        x = 4'd1;
        y = 4'd1;
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        checks++;
        if ({done_valid, start_ready, alu_a, alu_b} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL same_cycle_consume: got dv=%b rdy=%b a=%h b=%h, need 0 1 0 0",
                     done_valid, start_ready, alu_a, alu_b);
        end
        start_valid = 1'b0;
        issue_cmd(1'b0, 4'd2, 4'd2, lat);
        checks++;
        if ({lat == 4, hi, lo} !== {1'b1, 8'h04}) begin
            errors++;
            $display("FAIL after_backpressure: got lat=%0d hi=%h lo=%h, need 4 0 4", lat, hi, lo);
        end
        consume_done();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_valid = 1'b1;
        op = 1'b0;
        x = 4'd3;
        y = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({done_valid, hi, lo, div_by_zero, alu_a, alu_b} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got dv=%b hi=%h lo=%h dbz=%b a=%h b=%h, need all 0",
                     done_valid, hi, lo, div_by_zero, alu_a, alu_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({start_ready, done_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b dv=%b, need 1 0", start_ready, done_valid);
        end
        issue_cmd(1'b0, 4'd3, 4'd5, lat);
        checks++;
        if ({lat == 4, hi, lo} !== {1'b1, 8'h0F}) begin
            errors++;
            $display("FAIL mul_3x5_after_reset: got lat=%0d hi=%h lo=%h, need 4 0 f", lat, hi, lo);
        end
        consume_done();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle 4×4 unsigned multiplier/divider that acts as the initiator on the 4-bit ALU port. It drives operands and the operation select, and consumes the result and carry flag every cycle. Shift-and-add multiply and restoring divide each take four ALU passes. It sits beside the ALU as the controller that turns single-cycle nibble arithmetic into 8-bit products and quotient/remainder pairs.

## Interface
No parameters; width fixed at 4 bits to match the ALU.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_valid  in  1  command offered
- start_ready  out  1  command accepted when both high; high only in IDLE
- op  in  1  0 = multiply, 1 = divide; sampled at accept
- x  in  4  multiplicand / dividend; sampled at accept
- y  in  4  multiplier operand / divisor; sampled at accept
- done_valid  out  1  result available
- done_ready  in  1  result consumed when both high
- hi  out  4  mul: product[7:4]; div: remainder
- lo  out  4  mul: product[3:0]; div: quotient
- res_zero  out  1  {hi,lo} == 0
- div_by_zero  out  1  divide issued with y == 0
- alu_a, alu_b  out  4  ALU operands
- alu_aluop  out  2  ALU operation select
- alu_l  out  1  ALU logic/arith select; always 0 (arithmetic)
- alu_r  in  4  ALU result, combinational from alu_* outputs
- alu_carry, alu_zero, alu_sign  in  1  ALU flags; only alu_carry is used

## Operation
- States: IDLE → RUN (on accept) → DONE (after 4th iteration) → IDLE (on done_valid & done_ready).
- On accept: register op and y; cnt = 0.
  - Multiply: hi = 0, lo = x.
  - Divide: hi = 0, lo = x.
  - div_by_zero = op & (y == 0).
- ALU encodings (l = 0): 00 add a+b; 01 sub a+~b+1 (carry = 1 means no borrow); 10 b+1; 11 −b. This block uses only 00 and 01.
- RUN multiply iteration:
  - alu_a = hi, alu_b = y, alu_aluop = 00.
  - If lo[0] = 1, {c, s} = {alu_carry, alu_r}; else {0, hi}.
  - Then {hi, lo} = {c, s, lo[3:1]}.
- RUN divide iteration:
  - t = {hi, lo[3]} (5 bits); alu_a = t[3:0], alu_b = y, alu_aluop = 01.
  - q = t[4] | alu_carry.
  - hi = q ? alu_r : t[3:0]; lo = {lo[2:0], q}.
- Divide by zero runs the normal 4 iterations. It yields lo = 4'hF and hi = x with no special-casing, and raises div_by_zero.
- Outside RUN: alu_a = 0, alu_b = 0, alu_aluop = 00, alu_l = 0.
- res_zero is combinational from hi/lo and is meaningful only while done_valid is high.

## Timing
- Reset (async, any state): state = IDLE, hi = lo = 0, div_by_zero = 0, done_valid = 0, cnt = 0. start_ready = 1 once rst_n deasserts.
- Reset mid-RUN or mid-DONE abandons the operation; no partial result is flagged.
- Latency:
  - Accept at edge E. Iterations at edges E+1..E+4. done_valid high after E+4.
  - A new start is acceptable after the edge at which done is consumed.
- hi, lo, res_zero and div_by_zero stay stable while done_valid = 1 and done_ready = 0.
- start_ready = 0 in RUN and DONE. Commands offered then are ignored, not queued.
- done_valid & done_ready in the same cycle as start_valid: the done is consumed. The start is not accepted until the following IDLE cycle.
- The ALU is combinational; each iteration's alu_r/alu_carry are captured in the same cycle they are driven.

## Structure
- Shared package holds:
  - state enum {IDLE, RUN, DONE}
  - OP_MUL = 1'b0, OP_DIV = 1'b1
  - ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_INC = 2'b10, ALU_NEG = 2'b11
- One combinational sub-module, muldiv_step. It takes op, hi, lo, y, alu_r, alu_carry and produces alu_a, alu_aluop, next hi and next lo.
- The top module holds the FSM, counter and handshake registers.
- The ALU is instantiated by the parent and connected via the alu_* ports; it is not inside this block.

## Test plan
- Mul 7×6: done_valid rises exactly 4 cycles after accept, with hi = 4'h2, lo = 4'hA, res_zero = 0.
- Mul F×F (exercises alu_carry path): hi = 4'hE, lo = 4'h1. Also mul 0×9: hi = lo = 0, res_zero = 1.
- Div 13/4: lo = 4'h3, hi = 4'h1. Also div 15/1: lo = 4'hF, hi = 0. Div 14/15 (t[4] path not taken): lo = 0, hi = 4'hE.
- Div 9/0: lo = 4'hF, hi = 4'h9, div_by_zero = 1. Next command mul 2×3: div_by_zero = 0, lo = 4'h6.
- Backpressure:
  - Hold done_ready = 0 for 3 cycles: outputs stable, start_ready = 0, start_valid pulses ignored.
  - Raise done_ready: IDLE next cycle; the following start is accepted.
- Assert rst_n = 0 after 2 RUN iterations: all outputs 0 immediately. After release, start_ready = 1 and a fresh mul 3×5 gives hi = 0, lo = 4'hF.
